// File: rtl/cmsdk_uart_stimulus.sv
// Byte FIFO feeding an 8N1 UART transmitter that drives an MCU receive pin.
// Define CMSDK_UART_STIM_GAP_EN to follow every frame with GAP_BITS idle bit periods.
module cmsdk_uart_stimulus #(
    parameter int BAUDDIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_BITS   = 2
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    input  logic [7:0]                  DIN,
    input  logic                        DIN_VALID,
    output logic                        DIN_READY,
    output logic                        TXD,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUDDIV);
    localparam logic [CW-1:0] TIMER_LOAD = CW'(BAUDDIV - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
`ifdef CMSDK_UART_STIM_GAP_EN
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_BITS - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef CMSDK_UART_STIM_GAP_EN
        , GAP
`endif
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] timer, timer_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   level_q, level_nxt;
    logic          txd_q, txd_nxt;
    logic          busy_q, busy_nxt;
    logic          push, pop, next_frame;
    logic [7:0]    mem [FIFO_DEPTH];
`ifdef CMSDK_UART_STIM_GAP_EN
    logic [GW-1:0] gap_cnt, gap_nxt;
`endif

    // Ready comes from the registered level only, so a pop never frees a slot on its own edge.
    assign DIN_READY = (level_q != FULL_LEVEL);
    assign push      = DIN_VALID && DIN_READY;
    assign LEVEL     = level_q;
    assign TXD       = txd_q;
    assign BUSY      = busy_q;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        bit_nxt    = bit_idx;
        shift_nxt  = shift;
        pop        = 1'b0;
        next_frame = 1'b0;
`ifdef CMSDK_UART_STIM_GAP_EN
        gap_nxt    = gap_cnt;
`endif
        unique case (state)
            IDLE: next_frame = 1'b1;
            START: begin
                if (timer == '0) begin
                    state_nxt = DATA;
                    timer_nxt = TIMER_LOAD;
                    bit_nxt   = 3'd0;
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_nxt = TIMER_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                    end
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
            STOP: begin
                if (timer == '0) begin
`ifdef CMSDK_UART_STIM_GAP_EN
                    state_nxt = GAP;
                    timer_nxt = TIMER_LOAD;
                    gap_nxt   = GAP_LOAD;
`else
                    next_frame = 1'b1;
`endif
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
`ifdef CMSDK_UART_STIM_GAP_EN
            GAP: begin
                if (timer == '0) begin
                    if (gap_cnt == '0) begin
                        next_frame = 1'b1;
                    end else begin
                        gap_nxt   = gap_cnt - GW'(1);
                        timer_nxt = TIMER_LOAD;
                    end
                end else begin
                    timer_nxt = timer - CW'(1);
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // Shared frame-boundary rule: start the next byte straight away or fall back to idle.
        if (next_frame) begin
            if (level_q != '0) begin
                pop       = 1'b1;
                state_nxt = START;
                timer_nxt = TIMER_LOAD;
                shift_nxt = mem[rd_ptr];
            end else begin
                state_nxt = IDLE;
            end
        end

        level_nxt = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
        busy_nxt  = (state_nxt != IDLE) || (level_nxt != '0);
        unique case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shift_nxt[0];
            default: txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
`ifdef CMSDK_UART_STIM_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            level_q <= level_nxt;
            txd_q   <= txd_nxt;
            busy_q  <= busy_nxt;
`ifdef CMSDK_UART_STIM_GAP_EN
            gap_cnt <= gap_nxt;
`endif
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETn && push) begin
            mem[wr_ptr] <= DIN;
        end
    end

endmodule

// File: tb/tb_cmsdk_uart_stimulus.sv
// Scoreboard bench for cmsdk_uart_stimulus: accepted bytes are queued and a line decoder checks TXD frames.
module tb_cmsdk_uart_stimulus;
    localparam int BAUDDIV    = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int GAP_BITS   = 2;
`ifdef CMSDK_UART_STIM_GAP_EN
    localparam int FRAME_CYC  = (10 + GAP_BITS) * BAUDDIV;
`else
    localparam int FRAME_CYC  = 10 * BAUDDIV;
`endif

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic       DIN_VALID = 1'b0;
    logic       DIN_READY;
    logic       TXD;
    logic       BUSY;
    logic [4:0] LEVEL;

    int         checkCount = 0;
    int         errorCount = 0;
    int         cycle = 0;
    int         epoch = 0;
    logic [7:0] expQ[$];
    int         startLog[$];

    cmsdk_uart_stimulus #(
        .BAUDDIV   (BAUDDIV),
        .FIFO_DEPTH(FIFO_DEPTH),
        .GAP_BITS  (GAP_BITS)
    ) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .DIN      (DIN),
        .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY),
        .TXD      (TXD),
        .BUSY     (BUSY),
        .LEVEL    (LEVEL)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Offers one byte and waits (bounded) for acceptance; the byte is scoreboarded on acceptance.
    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        @(negedge CLK);
        DIN       = b;
        DIN_VALID = 1'b1;
        while (!DIN_READY && waited < 2000) begin
            @(negedge CLK);
            waited++;
        end
        if (!DIN_READY) begin
            checkOutput("push_timeout", 32'(DIN_READY), 32'd1);
            DIN_VALID = 1'b0;
        end else begin
            expQ.push_back(b);
            @(posedge CLK);
            #1 DIN_VALID = 1'b0;
        end
    endtask

    task automatic waitDrain(input int maxCyc);
        int n = 0;
        while ((BUSY || expQ.size() != 0) && n < maxCyc) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("drain_busy", 32'(BUSY), 32'd0);
    endtask

    // Line decoder: samples each bit at its centre and compares against the scoreboard.
    initial begin
        logic [7:0] data;
        logic       startBit;
        logic       stopBit;
        logic [7:0] want;
        int         ep;
        forever begin
            @(negedge CLK);
            if (RESETn && TXD === 1'b0) begin
                ep = epoch;
                startLog.push_back(cycle);
                repeat (BAUDDIV / 2) @(negedge CLK);
                startBit = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUDDIV) @(negedge CLK);
                    data[i] = TXD;
                end
                repeat (BAUDDIV) @(negedge CLK);
                stopBit = TXD;
                if (ep == epoch) begin
                    checkOutput("start_bit", 32'(startBit), 32'd0);
                    checkOutput("stop_bit", 32'(stopBit), 32'd1);
                    if (expQ.size() == 0) begin
                        checkCount++;
                        errorCount++;
                        $display("[TB] FAIL unexpected_frame: actual byte=0x%02h required=no frame", data);
                    end else begin
                        want = expQ.pop_front();
                        checkOutput("rx_byte", 32'(data), 32'(want));
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge CLK);
        $display("[TB] FAIL watchdog: actual=cycle budget exceeded required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] v;
        $display("[TB] start");

        // Reset state after the first edge with RESETn low.
        @(negedge CLK);
        checkOutput("reset_txd", 32'(TXD), 32'd1);
        checkOutput("reset_busy", 32'(BUSY), 32'd0);
        checkOutput("reset_level", 32'(LEVEL), 32'd0);
        checkOutput("reset_ready", 32'(DIN_READY), 32'd1);
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        repeat (3) @(negedge CLK);

        // Single byte 0x55: latency and BUSY length.
        $display("[TB] single byte");
        applyStimulus(8'h55);
        @(negedge CLK);
        checkOutput("single_level_k", 32'(LEVEL), 32'd1);
        checkOutput("single_txd_k", 32'(TXD), 32'd1);
        checkOutput("single_busy_k", 32'(BUSY), 32'd1);
        @(negedge CLK);
        checkOutput("single_txd_k1", 32'(TXD), 32'd0);
        checkOutput("single_level_k1", 32'(LEVEL), 32'd0);
        repeat (FRAME_CYC - 1) @(negedge CLK);
        checkOutput("single_busy_last", 32'(BUSY), 32'd1);
        @(negedge CLK);
        checkOutput("single_busy_fall", 32'(BUSY), 32'd0);
        checkOutput("single_txd_idle", 32'(TXD), 32'd1);
        waitDrain(400);

        // Back-to-back "AB" with a simultaneous push and pop.
        $display("[TB] back-to-back");
        startLog.delete();
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        @(negedge CLK);
        checkOutput("b2b_level_pushpop", 32'(LEVEL), 32'd1);
        waitDrain(800);
        checkOutput("b2b_frames", 32'(startLog.size()), 32'd2);
        if (startLog.size() == 2)
            checkOutput("b2b_spacing", 32'(startLog[1] - startLog[0]), 32'(FRAME_CYC));

        // Fill the FIFO, stall, and stream 40 bytes through wrapping pointers.
        $display("[TB] full fifo");
        for (int i = 0; i < 17; i++) begin
            v = 8'h60 + 8'(i);
            applyStimulus(v);
        end
        @(negedge CLK);
        checkOutput("full_level", 32'(LEVEL), 32'd16);
        checkOutput("full_ready", 32'(DIN_READY), 32'd0);
        checkOutput("full_busy", 32'(BUSY), 32'd1);
        for (int i = 17; i < 40; i++) begin
            v = 8'h60 + 8'(i);
            applyStimulus(v);
        end
        waitDrain(10000);
        checkOutput("full_level_end", 32'(LEVEL), 32'd0);

        // Reset during data bit 3 of 0xF0 with three bytes queued.
        $display("[TB] reset mid-frame");
        applyStimulus(8'hF0);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        repeat (68) @(negedge CLK);
        checkOutput("midrst_bit3", 32'(TXD), 32'd0);
        checkOutput("midrst_level", 32'(LEVEL), 32'd3);
        RESETn = 1'b0;
        expQ.delete();
        epoch++;
        startLog.delete();
        @(negedge CLK);
        checkOutput("midrst_txd", 32'(TXD), 32'd1);
        checkOutput("midrst_level0", 32'(LEVEL), 32'd0);
        checkOutput("midrst_busy", 32'(BUSY), 32'd0);
        checkOutput("midrst_ready", 32'(DIN_READY), 32'd1);
        RESETn = 1'b1;
        repeat (400) @(negedge CLK);
        checkOutput("midrst_no_frames", 32'(startLog.size()), 32'd0);
        checkOutput("midrst_txd_idle", 32'(TXD), 32'd1);
        checkOutput("midrst_busy_idle", 32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
